mmio_host_if: RTL and testbench

MMIO_HOST_IF -- requirements
Module: mmio_host_if

---
 rtl/mmio_host_if.sv | 163 ++++++++++++++++
 tb/tb_mmio_host_if.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_host_if.sv
// mmio_host_if: host MMIO window with per-channel character FIFOs,
// a sticky EXIT register and a stuck-PC watchdog.
module mmio_host_if #(
    parameter logic [31:0] BASE     = 32'h8000_0000,
    parameter int          CHANNELS = 2,
    parameter int          DEPTH    = 16,
    parameter int          TIMEOUT  = 100
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  stall,
    input  logic [31:0]           pc,
    input  logic                  wvalid,
    input  logic [31:0]           waddr,
    input  logic [31:0]           wdata,
    output logic                  wready,
    output logic                  hit,
    output logic [CHANNELS-1:0]   tx_valid,
    output logic [8*CHANNELS-1:0] tx_data,
    input  logic [CHANNELS-1:0]   tx_ready,
    output logic                  exit_valid,
    output logic [31:0]           exit_code,
    output logic                  timeout,
    output logic                  done
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * CHANNELS + 4);
    localparam logic [AW:0] ONE  = (AW + 1)'(1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } wd_state_t;

    logic [31:0]         offset;
    logic [29:0]         word;
    logic                in_win;
    logic                is_exit;
    logic                is_putc;
    logic                wr_ok;
    logic [CHANNELS-1:0] put_sel;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;

    wd_state_t   state;
    wd_state_t   state_nx;
    logic [15:0] cnt;
    logic [31:0] prev_pc;
    logic        same_pc;
    logic        inc;
    logic        reach;
    logic        exit_acc;
    logic        set_exit;
    logic        set_to;
    logic        wd_en;

    // Addresses below BASE wrap to a huge offset and fall outside the window.
    assign offset  = waddr - BASE;
    assign word    = offset[31:2];
    assign in_win  = offset < SPAN;
    assign hit     = wvalid & in_win;
    assign is_exit = in_win & (offset == 32'd0);
    assign is_putc = in_win & (offset[1:0] == 2'b00) & (word != 30'd0);

    // One-hot PUTC channel select from the word index.
    always_comb begin
        put_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            put_sel[c] = is_putc & (word == 30'(c + 1));
        end
    end

    assign wready = resetb & hit & ~(|(put_sel & full));
    assign wr_ok  = wvalid & wready;
    assign push   = put_sel & {CHANNELS{wr_ok}};
    assign pop    = tx_valid & tx_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [AW:0] wp;
        logic [AW:0] rp;
        logic [7:0]  mem [DEPTH];

        assign full[c] = (wp[AW] != rp[AW]) &&
                         (wp[AW-1:0] == rp[AW-1:0]);
        assign tx_valid[c] = wp != rp;
        assign tx_data[8*c +: 8] = mem[rp[AW-1:0]];

        // Pointer advance; push and pop are independent.
        always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push[c]) wp <= wp + ONE;
                if (pop[c])  rp <= rp + ONE;
            end
        end

        // Character storage; contents are don't-care after reset.
        always_ff @(posedge clk) begin
            if (push[c]) mem[wp[AW-1:0]] <= wdata[7:0];
        end
    end

    assign same_pc  = pc == prev_pc;
    assign inc      = (state == RUN) & ~stall & same_pc;
    assign reach    = inc & (cnt == 16'(TIMEOUT - 1));
    assign exit_acc = wr_ok & is_exit;

    // Watchdog state register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= RUN;
        else         state <= state_nx;
    end

    // Leave RUN on an accepted EXIT or on the counter hitting TIMEOUT.
    always_comb begin
        state_nx = state;
        if (state == RUN && (exit_acc || reach)) state_nx = HALT;
    end

    // Per-state actions; EXIT takes priority over a same-cycle timeout.
    always_comb begin
        set_exit = 1'b0;
        set_to   = 1'b0;
        wd_en    = 1'b0;
        unique case (state)
            RUN: begin
                set_exit = exit_acc;
                set_to   = reach & ~exit_acc;
                wd_en    = ~stall;
            end
            HALT: begin
            end
        endcase
    end

    // Sticky status, exit code and the stuck-PC counter.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            exit_valid <= 1'b0;
            exit_code  <= '0;
            timeout    <= 1'b0;
            cnt        <= '0;
            prev_pc    <= '0;
        end else begin
            if (set_exit) begin
                exit_valid <= 1'b1;
                exit_code  <= wdata;
            end
            if (set_to) timeout <= 1'b1;
            if (wd_en) begin
                cnt     <= same_pc ? cnt + 16'd1 : 16'd0;
                prev_pc <= pc;
            end
        end
    end

    assign done = exit_valid | timeout;

endmodule

// File: tb/tb_mmio_host_if.sv
// tb_mmio_host_if: directed and random stimulus checked against a
// queue-based reference model of the MMIO host window.
module tb_mmio_host_if;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          TMO  = 100;
    localparam int          DEP  = 16;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc = 32'h1000;
    logic        wvalid = 1'b0;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  tx_ready = '0;
    logic        wready;
    logic        hit;
    logic [1:0]  tx_valid;
    logic [15:0] tx_data;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic        timeout;
    logic        done;

    mmio_host_if #(
        .BASE(BASE), .CHANNELS(2), .DEPTH(DEP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .resetb(resetb), .stall(stall), .pc(pc),
        .wvalid(wvalid), .waddr(waddr), .wdata(wdata),
        .wready(wready), .hit(hit),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .exit_valid(exit_valid), .exit_code(exit_code),
        .timeout(timeout), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit pc_run = 1'b0;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    bit          m_exit;
    bit          m_to;
    logic [31:0] m_code;
    logic [31:0] m_prev;
    int          m_cnt;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        q0.delete();
        q1.delete();
        m_exit = 1'b0;
        m_to   = 1'b0;
        m_code = '0;
        m_prev = '0;
        m_cnt  = 0;
    endtask

    function automatic bit m_inwin();
        longint a = waddr;
        longint b = BASE;
        return wvalid && (a >= b) && (a <= b + 11);
    endfunction

    function automatic int m_chan();
        if (!m_inwin()) return -1;
        if (waddr == BASE + 32'd4) return 0;
        if (waddr == BASE + 32'd8) return 1;
        return -1;
    endfunction

    function automatic bit m_wready();
        int ch = m_chan();
        if (!resetb || !m_inwin()) return 1'b0;
        if (ch == 0 && q0.size() == DEP) return 1'b0;
        if (ch == 1 && q1.size() == DEP) return 1'b0;
        return 1'b1;
    endfunction

    task automatic compare();
        logic [1:0] v;
        v[0] = q0.size() != 0;
        v[1] = q1.size() != 0;
        chk("hit", 32'(hit), 32'(m_inwin()));
        chk("wready", 32'(wready), 32'(m_wready()));
        chk("tx_valid", 32'(tx_valid), 32'(v));
        if (v[0]) chk("tx_data0", 32'(tx_data[7:0]), 32'(q0[0]));
        if (v[1]) chk("tx_data1", 32'(tx_data[15:8]), 32'(q1[0]));
        chk("exit_valid", 32'(exit_valid), 32'(m_exit));
        chk("exit_code", exit_code, m_code);
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("done", 32'(done), 32'(m_exit | m_to));
    endtask

    task automatic model_step();
        bit acc;
        int ch;
        acc = wvalid && m_wready();
        ch  = m_chan();
        if (tx_ready[0] && q0.size() != 0) void'(q0.pop_front());
        if (tx_ready[1] && q1.size() != 0) void'(q1.pop_front());
        if (acc && ch == 0) q0.push_back(wdata[7:0]);
        if (acc && ch == 1) q1.push_back(wdata[7:0]);
        if (!m_exit && !m_to) begin
            if (acc && waddr == BASE) begin
                m_exit = 1'b1;
                m_code = wdata;
            end else if (!stall) begin
                if (pc == m_prev) begin
                    m_cnt++;
                    if (m_cnt == TMO) m_to = 1'b1;
                end else begin
                    m_cnt = 0;
                end
                m_prev = pc;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
        if (pc_run) pc = pc + 32'd4;
    endtask

    // Called at posedge+1; returns at posedge+2 with reset released.
    task automatic do_reset();
        #2 resetb = 1'b0;
        #1;
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_code", exit_code, 32'd0);
        m_reset();
        @(posedge clk);
        #2 resetb = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout got %0d exp 0", 1);
        $fatal(1);
    end

    initial begin
        int n;
        m_reset();
        wvalid = 1'b1;
        waddr  = BASE + 32'd4;
        wdata  = 32'h0000_0099;
        #2;
        chk("init_txv", 32'(tx_valid), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_exit", 32'(exit_valid), 32'd0);
        chk("init_to", 32'(timeout), 32'd0);
        chk("init_code", exit_code, 32'd0);
        chk("init_wready", 32'(wready), 32'd0);
        chk("init_hit", 32'(hit), 32'd1);
        @(posedge clk);
        #2 resetb = 1'b1;
        pc_run = 1'b1;
        cycle();
        chk("first_v", 32'(tx_valid), 32'd1);
        chk("first_d", 32'(tx_data[7:0]), 32'h99);
        wvalid = 1'b0;
        tx_ready = 2'b11;
        cycle();

        tx_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            wvalid = 1'b1;
            waddr  = BASE + 32'd4;
            wdata  = $urandom;
            wdata[7:0] = 8'(8'h41 + i);
            cycle();
            chk("r40_v", 32'(tx_valid), 32'd1);
            chk("r40_d", 32'(tx_data[7:0]), 32'(8'h41 + i));
        end
        wvalid = 1'b0;
        cycle();
        chk("r40_empty", 32'(tx_valid), 32'd0);

        tx_ready = 2'b00;
        for (int i = 0; i < 16; i++) begin
            wvalid = 1'b1;
            waddr  = BASE + 32'd8;
            wdata  = $urandom;
            wdata[7:0] = 8'(8'h60 + i);
            cycle();
        end
        wdata = $urandom;
        wdata[7:0] = 8'h70;
        #1;
        chk("r41_full", 32'(wready), 32'd0);
        chk("r41_hit", 32'(hit), 32'd1);
        cycle();
        tx_ready = 2'b10;
        cycle();
        tx_ready = 2'b00;
        #1;
        chk("r41_accept", 32'(wready), 32'd1);
        cycle();
        wvalid = 1'b0;
        tx_ready = 2'b10;
        for (int i = 1; i < 17; i++) begin
            chk("r41_order", 32'(tx_data[15:8]), 32'(8'h60 + i));
            cycle();
        end
        chk("r41_drained", 32'(tx_valid), 32'd0);

        wvalid = 1'b1;
        waddr  = BASE;
        wdata  = 32'h0000_002A;
        cycle();
        chk("r42_valid", 32'(exit_valid), 32'd1);
        chk("r42_code", exit_code, 32'h2A);
        chk("r42_done", 32'(done), 32'd1);
        wdata = 32'h0000_0007;
        cycle();
        chk("r42_hold", exit_code, 32'h2A);

        tx_ready = 2'b00;
        for (int i = 0; i < 5; i++) begin
            waddr = BASE + 32'd4;
            wdata = 32'(8'h30 + i);
            cycle();
        end
        wdata = 32'h0000_0055;
        do_reset();
        cycle();
        chk("r45_lat_v", 32'(tx_valid), 32'd1);
        chk("r45_lat_d", 32'(tx_data[7:0]), 32'h55);
        wvalid = 1'b0;
        tx_ready = 2'b11;
        cycle();
        chk("r45_empty", 32'(tx_valid), 32'd0);

        pc_run = 1'b0;
        pc = 32'h100;
        for (int i = 0; i < 100; i++) cycle();
        chk("r43_pre", 32'(timeout), 32'd0);
        pc = 32'h104;
        n = 0;
        while (n < 300 && timeout !== 1'b1) begin
            stall = (n >= 20 && n < 30);
            cycle();
            n++;
        end
        stall = 1'b0;
        chk("r43_cycles", 32'(n), 32'd111);
        wvalid = 1'b1;
        waddr  = BASE;
        wdata  = 32'h0000_0077;
        #1;
        chk("r43_exit_ack", 32'(wready), 32'd1);
        cycle();
        chk("r43_exit_ign", 32'(exit_valid), 32'd0);
        chk("r43_code_ign", exit_code, 32'd0);
        wvalid = 1'b0;

        do_reset();
        pc = 32'h200;
        for (int i = 0; i < 100; i++) cycle();
        wvalid = 1'b1;
        waddr  = BASE;
        wdata  = 32'h0000_0005;
        cycle();
        chk("r44_exit", 32'(exit_valid), 32'd1);
        chk("r44_to", 32'(timeout), 32'd0);
        wvalid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("r44_to_hold", 32'(timeout), 32'd0);

        for (int k = 0; k < 900; k++) begin
            int r;
            if (k == 0 || k == 450) do_reset();
            r = $urandom_range(0, 39);
            wvalid = ($urandom_range(0, 9) < 7);
            wdata  = $urandom;
            if (r == 0)      waddr = (k >= 450) ? BASE : BASE + 32'd4;
            else if (r < 15) waddr = BASE + 32'd4;
            else if (r < 29) waddr = BASE + 32'd8;
            else if (r < 33) waddr = BASE + 32'($urandom_range(1, 15));
            else if (r < 36) waddr = BASE - 32'($urandom_range(1, 8));
            else             waddr = $urandom;
            tx_ready = 2'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) begin
                pc = 32'h100 * 32'($urandom_range(0, 3));
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
